calc_token_sequencer: RTL and testbench

Parametrised next-generation control sequencer for the stack calculator. Sits between the token decoder/number builder and the calculation core. It accepts decoded tokens over a valid/ready handshake and forwards digits to the number builder and display buffer. On each operator it pushes the built operand and then the operator word to the core over valid/ready, and collects the final answer on "=". Adds configurable widths, operator codes, a watchdog timeout and an error state.

---
 rtl/calc_seq_pkg.sv | 26 ++
 rtl/calc_seq_watchdog.sv | 32 +++
 rtl/calc_token_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_calc_token_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_seq_pkg.sv
// Shared state encoding and operator-word helper for the calculator token sequencer.
package calc_seq_pkg;

  localparam int MAX_DATA_W  = 64;
  localparam int MAX_TOKEN_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SEND_NUM = 4'd1,
    ST_SEND_OP  = 4'd2,
    ST_WAIT_ANS = 4'd3,
    ST_DONE     = 4'd4,
    ST_ERROR    = 4'd5
  } seq_state_t;

  // Operator word: MSB of the data_w-wide word set, operator code in the LSBs.
  function automatic logic [MAX_DATA_W-1:0] op_word(input int data_w,
                                                    input logic [MAX_TOKEN_W-1:0] code);
    logic [MAX_DATA_W-1:0] word;
    word = '0;
    word[MAX_TOKEN_W-1:0] = code;
    word = word | (MAX_DATA_W'(1) << (data_w - 1));
    return word;
  endfunction

endpackage

// File: rtl/calc_seq_watchdog.sv
// Wait-state watchdog: counts cycles while enabled; o_trip marks the cycle on which
// the count reaches TIMEOUT_CYC. TIMEOUT_CYC = 0 never trips.
module calc_seq_watchdog #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_trip
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the number of completed cycles in the state, so the limit is hit
  // while the TIMEOUT_CYC-th waiting cycle is in progress.
  assign o_trip = (TIMEOUT_CYC != 0) && i_enable && (r_cnt == LAST);

endmodule

// File: rtl/calc_token_sequencer.sv
// Token sequencer between the decoder/number builder and the calculation core.
// Build option SEQ_STRICT_SYNTAX_EN: an operator with no pending operand faults to ERROR.
module calc_token_sequencer
  import calc_seq_pkg::*;
#(
  parameter int                 DATA_W      = 32,
  parameter int                 TOKEN_W     = 4,
  parameter logic [TOKEN_W-1:0] EQ_CODE     = 4'hE,
  parameter logic [TOKEN_W-1:0] CLR_CODE    = 4'hF,
  parameter int                 TIMEOUT_CYC = 1024,
  parameter int                 CNT_W       = 11
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tok_valid,
  output logic               tok_ready,
  input  logic               tok_is_number,
  input  logic [TOKEN_W-1:0] tok_code,
  input  logic [DATA_W-1:0]  built_number,
  output logic               digit_valid,
  output logic [TOKEN_W-1:0] digit_code,
  output logic               op_disp_valid,
  output logic [TOKEN_W-1:0] op_disp_code,
  output logic               nb_clear,
  output logic               calc_valid,
  input  logic               calc_ready,
  output logic               calc_is_op,
  output logic [DATA_W-1:0]  calc_data,
  input  logic               ans_valid_in,
  input  logic [DATA_W-1:0]  calc_answer,
  output logic               ans_valid,
  output logic [DATA_W-1:0]  ans_data,
  output logic               busy,
  output logic               error,
  output logic [3:0]         state_dbg
);

  // state    | meaning
  // IDLE     | taking digits, operators and clear
  // SEND_NUM | operand offered to core
  // SEND_OP  | operator word offered to core
  // WAIT_ANS | "=" sent, waiting for the core answer
  // DONE     | answer shown, only clear accepted
  // ERROR    | fault latched, only clear accepted

  seq_state_t         r_state, w_state_nxt;
  logic               r_have_operand, w_have_operand_nxt;
  logic [TOKEN_W-1:0] r_op, w_op_nxt;
  logic               r_tok_ready, r_busy, r_error;
  logic               r_digit_valid, w_digit_valid_nxt;
  logic [TOKEN_W-1:0] r_digit_code, w_digit_code_nxt;
  logic               r_op_disp_valid, w_op_disp_valid_nxt;
  logic [TOKEN_W-1:0] r_op_disp_code, w_op_disp_code_nxt;
  logic               r_nb_clear, w_nb_clear_nxt;
  logic               r_calc_valid, w_calc_valid_nxt;
  logic               r_calc_is_op, w_calc_is_op_nxt;
  logic [DATA_W-1:0]  r_calc_data, w_calc_data_nxt;
  logic               r_ans_valid, w_ans_valid_nxt;
  logic [DATA_W-1:0]  r_ans_data, w_ans_data_nxt;

  logic              w_tok_accept, w_tok_is_clr;
  logic              w_wd_clear, w_wd_enable, w_wd_trip;
  logic [DATA_W-1:0] w_op_word;

  assign w_tok_accept = tok_valid & r_tok_ready;
  assign w_tok_is_clr = ~tok_is_number & (tok_code == CLR_CODE);
  assign w_op_word    = DATA_W'(op_word(DATA_W, MAX_TOKEN_W'(r_op)));

  assign w_wd_enable = (r_state == ST_SEND_NUM) || (r_state == ST_SEND_OP) ||
                       (r_state == ST_WAIT_ANS);
  assign w_wd_clear  = (w_state_nxt != r_state);

  calc_seq_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .i_clock (clock),
    .i_reset (reset),
    .i_clear (w_wd_clear),
    .i_enable(w_wd_enable),
    .o_trip  (w_wd_trip)
  );

  always_comb begin
    w_state_nxt         = r_state;
    w_have_operand_nxt  = r_have_operand;
    w_op_nxt            = r_op;
    w_digit_valid_nxt   = 1'b0;
    w_digit_code_nxt    = r_digit_code;
    w_op_disp_valid_nxt = 1'b0;
    w_op_disp_code_nxt  = r_op_disp_code;
    w_nb_clear_nxt      = 1'b0;
    w_calc_valid_nxt    = r_calc_valid;
    w_calc_is_op_nxt    = r_calc_is_op;
    w_calc_data_nxt     = r_calc_data;
    w_ans_valid_nxt     = 1'b0;
    w_ans_data_nxt      = r_ans_data;
    case (r_state)
      ST_IDLE: begin
        if (w_tok_accept) begin
          if (tok_is_number) begin
            w_digit_valid_nxt  = 1'b1;
            w_digit_code_nxt   = tok_code;
            w_have_operand_nxt = 1'b1;
          end else if (w_tok_is_clr) begin
            w_nb_clear_nxt     = 1'b1;
            w_have_operand_nxt = 1'b0;
          end else if (r_have_operand) begin
            w_op_nxt            = tok_code;
            w_op_disp_valid_nxt = 1'b1;
            w_op_disp_code_nxt  = tok_code;
            w_calc_data_nxt     = built_number;
            w_calc_is_op_nxt    = 1'b0;
            w_calc_valid_nxt    = 1'b1;
            w_state_nxt         = ST_SEND_NUM;
          end
`ifdef SEQ_STRICT_SYNTAX_EN
          else begin
            w_state_nxt = ST_ERROR;
          end
`endif
        end
      end
      ST_SEND_NUM: begin
        if (calc_ready) begin
          w_nb_clear_nxt     = 1'b1;
          w_have_operand_nxt = 1'b0;
          w_calc_data_nxt    = w_op_word;
          w_calc_is_op_nxt   = 1'b1;
          w_state_nxt        = ST_SEND_OP;
        end else if (w_wd_trip) begin
          w_calc_valid_nxt = 1'b0;
          w_calc_is_op_nxt = 1'b0;
          w_state_nxt      = ST_ERROR;
        end
      end
      ST_SEND_OP: begin
        if (calc_ready) begin
          w_calc_valid_nxt = 1'b0;
          w_calc_is_op_nxt = 1'b0;
          w_state_nxt      = (r_op == EQ_CODE) ? ST_WAIT_ANS : ST_IDLE;
        end else if (w_wd_trip) begin
          w_calc_valid_nxt = 1'b0;
          w_calc_is_op_nxt = 1'b0;
          w_state_nxt      = ST_ERROR;
        end
      end
      ST_WAIT_ANS: begin
        if (ans_valid_in) begin
          w_ans_data_nxt  = calc_answer;
          w_ans_valid_nxt = 1'b1;
          w_state_nxt     = ST_DONE;
        end else if (w_wd_trip) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (w_tok_accept && w_tok_is_clr) begin
          w_nb_clear_nxt     = 1'b1;
          w_have_operand_nxt = 1'b0;
          w_state_nxt        = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_have_operand  <= 1'b0;
      r_op            <= '0;
      r_tok_ready     <= 1'b1;
      r_busy          <= 1'b0;
      r_error         <= 1'b0;
      r_digit_valid   <= 1'b0;
      r_digit_code    <= '0;
      r_op_disp_valid <= 1'b0;
      r_op_disp_code  <= '0;
      r_nb_clear      <= 1'b0;
      r_calc_valid    <= 1'b0;
      r_calc_is_op    <= 1'b0;
      r_calc_data     <= '0;
      r_ans_valid     <= 1'b0;
      r_ans_data      <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_have_operand  <= w_have_operand_nxt;
      r_op            <= w_op_nxt;
      r_tok_ready     <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE) ||
                         (w_state_nxt == ST_ERROR);
      r_busy          <= (w_state_nxt != ST_IDLE);
      r_error         <= (w_state_nxt == ST_ERROR);
      r_digit_valid   <= w_digit_valid_nxt;
      r_digit_code    <= w_digit_code_nxt;
      r_op_disp_valid <= w_op_disp_valid_nxt;
      r_op_disp_code  <= w_op_disp_code_nxt;
      r_nb_clear      <= w_nb_clear_nxt;
      r_calc_valid    <= w_calc_valid_nxt;
      r_calc_is_op    <= w_calc_is_op_nxt;
      r_calc_data     <= w_calc_data_nxt;
      r_ans_valid     <= w_ans_valid_nxt;
      r_ans_data      <= w_ans_data_nxt;
    end
  end

  assign tok_ready     = r_tok_ready;
  assign digit_valid   = r_digit_valid;
  assign digit_code    = r_digit_code;
  assign op_disp_valid = r_op_disp_valid;
  assign op_disp_code  = r_op_disp_code;
  assign nb_clear      = r_nb_clear;
  assign calc_valid    = r_calc_valid;
  assign calc_is_op    = r_calc_is_op;
  assign calc_data     = r_calc_data;
  assign ans_valid     = r_ans_valid;
  assign ans_data      = r_ans_data;
  assign busy          = r_busy;
  assign error         = r_error;
  assign state_dbg     = r_state;

endmodule

// File: tb/tb_calc_token_sequencer.sv
// Bench for calc_token_sequencer: directed scenarios plus random tokens, checked each
// cycle against a queue-based model of the words owed to the core.
module tb_calc_token_sequencer;

  localparam int         DW  = 32;
  localparam int         TW  = 4;
  localparam int         TO  = 8;
  localparam logic [3:0] EQ  = 4'hE;
  localparam logic [3:0] CLR = 4'hF;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          tok_valid = 1'b0;
  logic          tok_is_number = 1'b0;
  logic [TW-1:0] tok_code = '0;
  logic [DW-1:0] built_number = '0;
  logic          calc_ready = 1'b0;
  logic          ans_valid_in = 1'b0;
  logic [DW-1:0] calc_answer = '0;

  logic          tok_ready, digit_valid, op_disp_valid, nb_clear;
  logic [TW-1:0] digit_code, op_disp_code;
  logic          calc_valid, calc_is_op, ans_valid, busy, error;
  logic [DW-1:0] calc_data, ans_data;
  logic [3:0]    state_dbg;

  calc_token_sequencer #(
    .DATA_W(DW), .TOKEN_W(TW), .EQ_CODE(EQ), .CLR_CODE(CLR),
    .TIMEOUT_CYC(TO), .CNT_W(4)
  ) dut (
    .clock(clock), .reset(reset),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_number(tok_is_number),
    .tok_code(tok_code), .built_number(built_number),
    .digit_valid(digit_valid), .digit_code(digit_code),
    .op_disp_valid(op_disp_valid), .op_disp_code(op_disp_code), .nb_clear(nb_clear),
    .calc_valid(calc_valid), .calc_ready(calc_ready), .calc_is_op(calc_is_op),
    .calc_data(calc_data), .ans_valid_in(ans_valid_in), .calc_answer(calc_answer),
    .ans_valid(ans_valid), .ans_data(ans_data), .busy(busy), .error(error),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: the words still owed to the core sit in a queue; the mode follows from it.
  logic [DW-1:0] m_q[$];
  bit            m_fault, m_await, m_done, m_have;
  int            m_wait;
  logic [TW-1:0] m_op;
  logic [DW-1:0] m_ans;
  bit            e_dv, e_opv, e_nbc, e_av;
  logic [TW-1:0] e_dcode, e_ocode;

  function automatic int m_state();
    if (m_fault)         return 5;
    if (m_q.size() == 2) return 1;
    if (m_q.size() == 1) return 2;
    if (m_await)         return 3;
    if (m_done)          return 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_fault = 0; m_await = 0; m_done = 0; m_have = 0; m_wait = 0;
    m_op = '0; m_ans = '0;
    e_dv = 0; e_opv = 0; e_nbc = 0; e_av = 0; e_dcode = '0; e_ocode = '0;
  endtask

  task automatic timeout_tick();
    m_wait++;
    if (TO != 0 && m_wait == TO) begin
      m_fault = 1; m_await = 0; m_q.delete();
    end
  endtask

  task automatic model_step();
    bit acc, clr;
    acc = tok_valid && (m_q.size() == 0) && !m_await;
    clr = !tok_is_number && (tok_code == CLR);
    e_dv = 0; e_opv = 0; e_nbc = 0; e_av = 0;
    if (m_fault || m_done) begin
      if (acc && clr) begin m_fault = 0; m_done = 0; e_nbc = 1; m_have = 0; end
    end else if (m_q.size() != 0) begin
      if (calc_ready) begin
        void'(m_q.pop_front());
        m_wait = 0;
        if (m_q.size() == 1) begin e_nbc = 1; m_have = 0; end
        else if (m_op == EQ) m_await = 1;
      end else timeout_tick();
    end else if (m_await) begin
      if (ans_valid_in) begin m_ans = calc_answer; e_av = 1; m_await = 0; m_done = 1; end
      else timeout_tick();
    end else if (acc) begin
      if (tok_is_number) begin e_dv = 1; e_dcode = tok_code; m_have = 1; end
      else if (clr) begin e_nbc = 1; m_have = 0; end
      else if (m_have) begin
        m_op = tok_code; e_opv = 1; e_ocode = tok_code; m_wait = 0;
        m_q.push_back(built_number);
        m_q.push_back({1'b1, {(DW-1-TW){1'b0}}, tok_code});
      end else begin
`ifdef SEQ_STRICT_SYNTAX_EN
        m_fault = 1;
`endif
      end
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      chk("state_dbg", 64'(state_dbg), 64'(m_state()));
      chk("tok_ready", 64'(tok_ready), 64'((m_q.size() == 0) && !m_await));
      chk("busy", 64'(busy), 64'(m_state() != 0));
      chk("error", 64'(error), 64'(m_fault));
      chk("calc_valid", 64'(calc_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("calc_data", 64'(calc_data), 64'(m_q[0]));
        chk("calc_is_op", 64'(calc_is_op), 64'(m_q.size() == 1));
      end
      chk("digit_valid", 64'(digit_valid), 64'(e_dv));
      if (e_dv) chk("digit_code", 64'(digit_code), 64'(e_dcode));
      chk("op_disp_valid", 64'(op_disp_valid), 64'(e_opv));
      if (e_opv) chk("op_disp_code", 64'(op_disp_code), 64'(e_ocode));
      chk("nb_clear", 64'(nb_clear), 64'(e_nbc));
      chk("ans_valid", 64'(ans_valid), 64'(e_av));
      chk("ans_data", 64'(ans_data), 64'(m_ans));
    end
  end

  logic [DW-1:0] word_log[$];
  logic [TW-1:0] dig_log[$];
  always @(negedge clock) begin
    if (calc_valid && calc_ready) word_log.push_back(calc_data);
    if (digit_valid) dig_log.push_back(digit_code);
  end

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic send_tok(input logic num, input logic [TW-1:0] code);
    tok_valid = 1'b1; tok_is_number = num; tok_code = code;
    cyc();
    tok_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, expected finish before t=2000000");
    $fatal(1);
  end

  initial begin
    int n;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("lit_rst_tok_ready", 64'(tok_ready), 64'(1));
    chk("lit_rst_state", 64'(state_dbg), 64'(0));
    chk("lit_rst_calc_valid", 64'(calc_valid), 64'(0));
    chk("lit_rst_busy", 64'(busy), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    check_en = 1'b1;

    // 12 + 3 = with the core always ready
    word_log.delete(); dig_log.delete();
    calc_ready = 1'b1;
    send_tok(1'b1, 4'd1);
    send_tok(1'b1, 4'd2);
    built_number = 32'd12;
    send_tok(1'b0, 4'hA);
    chk("lit_op_disp_code", 64'(op_disp_code), 64'hA);
    cyc(); cyc();
    send_tok(1'b1, 4'd3);
    built_number = 32'd3;
    send_tok(1'b0, EQ);
    cyc(); cyc();
    chk("lit_wait_ans_state", 64'(state_dbg), 64'(3));
    chk("lit_digits_n", 64'(dig_log.size()), 64'(3));
    if (dig_log.size() == 3) begin
      chk("lit_digit0", 64'(dig_log[0]), 64'(1));
      chk("lit_digit1", 64'(dig_log[1]), 64'(2));
    end
    chk("lit_words_n", 64'(word_log.size()), 64'(4));
    if (word_log.size() == 4) begin
      chk("lit_word0", 64'(word_log[0]), 64'd12);
      chk("lit_word1", 64'(word_log[1]), 64'h8000000A);
      chk("lit_word2", 64'(word_log[2]), 64'd3);
      chk("lit_word3", 64'(word_log[3]), 64'h8000000E);
    end

    calc_answer = 32'd15; ans_valid_in = 1'b1;
    cyc();
    ans_valid_in = 1'b0;
    chk("lit_ans_valid", 64'(ans_valid), 64'(1));
    chk("lit_ans_data", 64'(ans_data), 64'd15);
    chk("lit_done_state", 64'(state_dbg), 64'(4));
    cyc();
    chk("lit_ans_pulse_end", 64'(ans_valid), 64'(0));
    send_tok(1'b1, 4'd5);
    chk("lit_done_ignores_digit", 64'(state_dbg), 64'(4));
    chk("lit_done_no_digit", 64'(digit_valid), 64'(0));
    send_tok(1'b0, CLR);
    chk("lit_done_clr_state", 64'(state_dbg), 64'(0));
    chk("lit_done_clr_nb", 64'(nb_clear), 64'(1));

    // core stalls 5 cycles on the operand
    built_number = 32'd7;
    send_tok(1'b1, 4'd7);
    calc_ready = 1'b0;
    send_tok(1'b0, 4'hA);
    repeat (5) cyc();
    chk("lit_stall_state", 64'(state_dbg), 64'(1));
    chk("lit_stall_data", 64'(calc_data), 64'd7);
    calc_ready = 1'b1;
    cyc();
    chk("lit_stall_release", 64'(state_dbg), 64'(2));
    cyc();

    // watchdog on a silent core
    calc_ready = 1'b0;
    send_tok(1'b1, 4'd4);
    send_tok(1'b0, 4'hA);
    n = 0;
    for (int k = 0; k < 20 && state_dbg != 4'd5; k++) begin
      cyc();
      n++;
    end
    chk("lit_timeout_cycles", 64'(n), 64'(TO));
    chk("lit_timeout_error", 64'(error), 64'(1));
    chk("lit_timeout_calc_valid", 64'(calc_valid), 64'(0));
    send_tok(1'b0, CLR);
    chk("lit_err_clr_state", 64'(state_dbg), 64'(0));
    chk("lit_err_clr_error", 64'(error), 64'(0));

    // leading operator with no operand
    send_tok(1'b0, 4'hA);
    chk("lit_lead_op_disp", 64'(op_disp_valid), 64'(0));
`ifdef SEQ_STRICT_SYNTAX_EN
    chk("lit_lead_op_state", 64'(state_dbg), 64'(5));
    send_tok(1'b0, CLR);
`else
    chk("lit_lead_op_state", 64'(state_dbg), 64'(0));
`endif

    // reset while the operator word is on the bus
    calc_ready = 1'b0;
    send_tok(1'b1, 4'd2);
    send_tok(1'b0, 4'hB);
    calc_ready = 1'b1;
    cyc();
    calc_ready = 1'b0;
    chk("lit_pre_reset_state", 64'(state_dbg), 64'(2));
    check_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("lit_reset_calc_valid", 64'(calc_valid), 64'(0));
    chk("lit_reset_tok_ready", 64'(tok_ready), 64'(1));
    chk("lit_reset_state", 64'(state_dbg), 64'(0));
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    check_en = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      int r, p_rdy;
      p_rdy = ((i / 500) % 2 == 1) ? 4 : 8;
      tok_valid     = ($urandom % 2) == 1;
      tok_is_number = ($urandom % 2) == 1;
      r = $urandom % 100;
      if (tok_is_number)  tok_code = TW'($urandom % 10);
      else if (r < 12)    tok_code = CLR;
      else if (r < 30)    tok_code = EQ;
      else                tok_code = TW'($urandom % 14);
      built_number = $urandom;
      calc_ready   = ($urandom % 10) < p_rdy;
      ans_valid_in = ($urandom % 10) < 3;
      calc_answer  = $urandom;
      cyc();
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
